// File: rtl/sdpram_pkg.sv
// Shared types and helpers for the clearable simple dual-port RAM.
package sdpram_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  localparam int MAXW = 256;
  localparam int MAXL = 32;

  function automatic int lanes(input int dw, input int bs);
    return dw / bs;
  endfunction

  // Replace the lanes selected by be with the matching lanes of new_w.
  function automatic logic [MAXW-1:0] lane_merge(
    input logic [MAXW-1:0] old_w,
    input logic [MAXW-1:0] new_w,
    input logic [MAXL-1:0] be,
    input int              bs
  );
    logic [MAXW-1:0] m;
    m = '0;
    for (int j = 0; j < MAXW; j++) begin
      if ((j / bs) < MAXL) m[j] = be[j / bs];
    end
    return (old_w & ~m) | (new_w & m);
  endfunction

endpackage

// File: rtl/sdpram_sync_clr_core.sv
// Inferred array: per-lane write, registered read-first output.
module sdpram_sync_clr_core
  import sdpram_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 18,
  parameter int BS = 9
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [DW-1:0]    i_wdata,
  input  logic [DW/BS-1:0] i_wbe,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [DW-1:0]    o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_q;
  logic [MAXW-1:0] w_m;

  assign w_m = lane_merge(MAXW'(r_mem[i_waddr]), MAXW'(i_wdata),
                          MAXL'(i_wbe), BS);

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= w_m[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (i_rst) r_q <= '0;
    else if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/sdpram_sync_clr.sv
// Single-clock SDP RAM with byte lanes and hardware clear sweep.
// Define SDPRAM_SYNC_CLR_FWD_EN for write-to-read forwarding.
module sdpram_sync_clr
  import sdpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18,
  parameter int BYTE_SIZE  = 9,
  parameter int OUTPUT_REG = 0,
  parameter int CLR_ON_RST = 1,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr_req,
  output logic                            clr_busy,
  input  logic                            wr_en,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic [DATA_WIDTH/BYTE_SIZE-1:0] wr_byte_en,
  input  logic                            rd_en,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            rd_valid
);

  localparam int NL = lanes(DATA_WIDTH, BYTE_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_busy;
  logic                  r_rst_d;
  logic                  r_v1;

  logic                  w_clr;
  logic                  w_uwe;
  logic                  w_ure;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [NL-1:0]         w_wbe;
  logic [DATA_WIDTH-1:0] w_q;
  logic [DATA_WIDTH-1:0] w_rd1;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] o,
    input logic [DATA_WIDTH-1:0] n,
    input logic [NL-1:0]         be
  );
    logic [MAXW-1:0] t;
    t = lane_merge(MAXW'(o), MAXW'(n), MAXL'(be), BYTE_SIZE);
    return t[DATA_WIDTH-1:0];
  endfunction

  assign w_clr   = (r_state == ST_CLEAR) && !rst;
  assign w_uwe   = (r_state == ST_IDLE) && !rst && wr_en;
  assign w_ure   = (r_state == ST_IDLE) && !rst && rd_en;
  assign w_we    = w_clr || w_uwe;
  assign w_waddr = w_clr ? r_cnt : wr_addr;
  assign w_wdata = w_clr ? CLR_VALUE : wr_data;
  assign w_wbe   = w_clr ? '1 : wr_byte_en;

  // r_rst_d marks the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_rst_d <= 1'b1;
    end else begin
      r_rst_d <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if ((CLR_ON_RST != 0 && r_rst_d) || clr_req) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign clr_busy = r_busy;

  sdpram_sync_clr_core #(
    .AW(ADDR_WIDTH),
    .DW(DATA_WIDTH),
    .BS(BYTE_SIZE)
  ) u_core (
    .clk    (clk),
    .i_rst  (rst),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_wbe  (w_wbe),
    .i_re   (w_ure),
    .i_raddr(rd_addr),
    .o_rdata(w_q)
  );

  always_ff @(posedge clk) begin
    if (rst) r_v1 <= 1'b0;
    else r_v1 <= w_ure;
  end

`ifdef SDPRAM_SYNC_CLR_FWD_EN
  logic [DATA_WIDTH-1:0] r_fdata;
  logic [NL-1:0]         r_fbe;

  // Lanes written alongside the read are patched over the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fdata <= '0;
      r_fbe   <= '0;
    end else if (w_ure) begin
      r_fdata <= wr_data;
      r_fbe   <= (w_uwe && wr_addr == rd_addr) ? wr_byte_en : '0;
    end
  end

  assign w_rd1 = merge(w_q, r_fdata, r_fbe);
`else
  assign w_rd1 = w_q;
`endif

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] r_q2;
      logic                  r_v2;
      logic [DATA_WIDTH-1:0] w_d2;
`ifdef SDPRAM_SYNC_CLR_FWD_EN
      logic [ADDR_WIDTH-1:0] r_raddr1;
      always_ff @(posedge clk) begin
        if (rst) r_raddr1 <= '0;
        else if (w_ure) r_raddr1 <= rd_addr;
      end
      assign w_d2 = (w_uwe && wr_addr == r_raddr1) ?
                    merge(w_rd1, wr_data, wr_byte_en) : w_rd1;
`else
      assign w_d2 = w_rd1;
`endif
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q2 <= '0;
          r_v2 <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_q2 <= w_d2;
        end
      end
      assign rd_data  = r_q2;
      assign rd_valid = r_v2;
    end else begin : g_noreg
      assign rd_data  = w_rd1;
      assign rd_valid = r_v1;
    end
  endgenerate

endmodule

// File: tb/tb_sdpram_sync_clr.sv
// Scoreboard bench: two DUTs (latency 1 and 2) against an array model.
module tb_sdpram_sync_clr;

`ifdef SDPRAM_SYNC_CLR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [17:0] wr_data = '0;
  logic [1:0]  wr_byte_en = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic        busy0, busy1, rv0, rv1;
  logic [17:0] rd0, rd1;

  int checks = 0;
  int errors = 0;

  logic [17:0] q0[$];
  logic [17:0] q1[$];

  logic [17:0] mem [16];
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  bit          m_rstp = 1'b0;
  bit          p_v = 1'b0;
  logic [3:0]  p_a;
  logic [17:0] p_d;

  always #5 clk = ~clk;

  sdpram_sync_clr #(
    .ADDR_WIDTH(4), .DATA_WIDTH(18), .BYTE_SIZE(9),
    .OUTPUT_REG(0), .CLR_ON_RST(1), .CLR_VALUE(18'h0)
  ) u0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd0), .rd_valid(rv0)
  );

  sdpram_sync_clr #(
    .ADDR_WIDTH(4), .DATA_WIDTH(18), .BYTE_SIZE(9),
    .OUTPUT_REG(1), .CLR_ON_RST(1), .CLR_VALUE(18'h0)
  ) u1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd1), .rd_valid(rv1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] mrg(input logic [17:0] o,
                                      input logic [17:0] n,
                                      input logic [1:0] be);
    logic [17:0] r;
    r = o;
    for (int l = 0; l < 2; l++) if (be[l]) r[l*9 +: 9] = n[l*9 +: 9];
    return r;
  endfunction

  // One clock of stimulus; the model advances with the same inputs.
  task automatic cyc(input bit r, input bit cq, input bit we,
                     input logic [3:0] wa, input logic [17:0] wd,
                     input logic [1:0] be, input bit re,
                     input logic [3:0] ra);
    logic [17:0] d;
    @(negedge clk);
    rst = r; clr_req = cq; wr_en = we; wr_addr = wa;
    wr_data = wd; wr_byte_en = be; rd_en = re; rd_addr = ra;
    if (p_v) begin
      if (!r) begin
        d = p_d;
        if (FWD && !m_busy && we && wa == p_a) d = mrg(d, wd, be);
        q1.push_back(d);
      end
      p_v = 1'b0;
    end
    if (r) begin
      m_busy = 1'b0; m_cnt = 0; m_rstp = 1'b1;
    end else begin
      if (!m_busy) begin
        if (re) begin
          d = mem[ra];
          if (FWD && we && wa == ra) d = mrg(d, wd, be);
          q0.push_back(d);
          p_v = 1'b1; p_a = ra; p_d = d;
        end
        if (we) mem[wa] = mrg(mem[wa], wd, be);
        if (m_rstp || cq) begin
          m_busy = 1'b1; m_cnt = 0;
        end
      end else begin
        mem[m_cnt] = 18'h0;
        m_cnt++;
        if (m_cnt == 16) m_busy = 1'b0;
      end
      m_rstp = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("busy0", {31'b0, busy0}, {31'b0, m_busy});
    chk("busy1", {31'b0, busy1}, {31'b0, m_busy});
    if (r) begin
      chk("rst_rv0", {31'b0, rv0}, 32'h0);
      chk("rst_rv1", {31'b0, rv1}, 32'h0);
      chk("rst_rd0", {14'b0, rd0}, 32'h0);
      chk("rst_rd1", {14'b0, rd1}, 32'h0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [17:0] d,
                    input logic [1:0] be);
    cyc(0, 0, 1, a, d, be, 0, 0);
  endtask

  task automatic rd(input logic [3:0] a);
    cyc(0, 0, 0, 0, 0, 0, 1, a);
  endtask

  always @(posedge clk) begin
    #1;
    if (rv0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd0_unexpected actual=%0h required=none", rd0);
      end else chk("rd0", {14'b0, rd0}, {14'b0, q0.pop_front()});
    end
  end

  always @(posedge clk) begin
    #1;
    if (rv1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd1_unexpected actual=%0h required=none", rd1);
      end else chk("rd1", {14'b0, rd1}, {14'b0, q1.pop_front()});
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 18'h0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(20);
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle(3);

    wr(5, 18'h3FFFF, 2'b01);
    rd(5);
    idle(3);

    for (int i = 0; i < 16; i++) wr(4'(i), 18'h15555, 2'b11);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 3, 18'h2AAAA, 2'b11, 1, 3);
    cyc(0, 1, 0, 0, 0, 0, 1, 4);
    idle(16);
    rd(3);
    idle(3);

    for (int i = 0; i < 16; i++) wr(4'(i), 18'($urandom), 2'b11);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(8);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(20);
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle(3);

    wr(1, 18'h00111, 2'b11);
    wr(2, 18'h00222, 2'b11);
    wr(3, 18'h00333, 2'b11);
    rd(1); rd(2); rd(3);
    idle(4);

    wr(7, 18'h00AAA, 2'b11);
    cyc(0, 0, 1, 7, 18'h12345, 2'b11, 1, 7);
    idle(2);
    rd(7);
    wr(7, 18'h3FE00, 2'b10);
    idle(3);

    for (int n = 0; n < 500; n++) begin
      logic [3:0] wa, ra;
      wa = 4'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      cyc(0, $urandom_range(0, 63) == 0, 1'($urandom), wa,
          18'($urandom), 2'($urandom), 1'($urandom), ra);
    end
    idle(20);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdpram_sync_clr.md
Name: sdpram_sync_clr

Overview:
- Single-clock simple dual-port RAM: one write port, one read port, both on `clk`.
- Generalises the fixed 1024x18 two-clock wrapper in four ways: parametric depth and width, per-byte write enables, optional output register with a read-valid strobe, and a hardware clear engine that sweeps the whole array to a constant.
- Used for per-frame tracking tables (histograms, template buffers) that must be zeroed between frames without a software write loop.

Parameters:
- ADDR_WIDTH, 10, address bits; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 18, word width; must be a multiple of BYTE_SIZE.
- BYTE_SIZE, 9, bits per byte lane; legal values 8 or 9.
- OUTPUT_REG, 0, 1 adds an output register stage, so read latency goes from 1 to 2.
- CLR_ON_RST, 1, 1 starts a full clear automatically when `rst` is released.
- CLR_VALUE, 0, DATA_WIDTH-bit word written to every location during a clear.

Ports:
- clk  in  1  the single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  one-cycle pulse; requests a full-array clear.
- clr_busy  out  1  high while a clear sweep is in progress.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_byte_en  in  DATA_WIDTH/BYTE_SIZE  per-lane write enable; bit i covers data[i*BYTE_SIZE +: BYTE_SIZE].
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  high for exactly one cycle, aligned with the corresponding `rd_data`.

Behaviour:
- Reset values while `rst` is high: rd_data=0, rd_valid=0, clr_busy=0, FSM=IDLE, clear counter=0.
- `rst` does not alter array contents.
- FSM has two states, IDLE and CLEAR:
  - IDLE -> CLEAR on the first cycle after `rst` falls, if CLR_ON_RST=1.
  - IDLE -> CLEAR on any cycle with clr_req=1.
  - CLEAR -> IDLE after the write to address DEPTH-1.
- In CLEAR, the counter writes CLR_VALUE (all lanes) to address cnt, then increments by one per cycle.
  - The sweep takes exactly DEPTH cycles.
  - clr_busy is registered: high for exactly those DEPTH cycles, low the cycle after the last write.
- In CLEAR, user wr_en and rd_en are ignored:
  - no write, no read, rd_valid=0, rd_data holds its value;
  - clr_req is also ignored (no restart, no queueing).
- clr_req asserted in the same cycle that CLEAR exits to IDLE is ignored. clr_req in the following cycle starts a new sweep.
- `rst` asserted mid-sweep:
  - the sweep aborts; already-cleared locations stay cleared;
  - after release, a fresh sweep starts from address 0 if CLR_ON_RST=1.
- User write (IDLE only): on wr_en=1, only the lanes with wr_byte_en set are written. wr_byte_en=0 with wr_en=1 is a no-op.
- User read (IDLE only):
  - OUTPUT_REG=0: rd_en sampled in cycle N gives rd_data/rd_valid in cycle N+1.
  - OUTPUT_REG=1: same, but in cycle N+2.
  - With no read, rd_data holds its last value and rd_valid=0.
  - Back-to-back reads sustain one result per cycle.
- Read and write to the same address in the same cycle, macro off: read returns the old contents (read-first).
- Addresses wrap naturally; out-of-range addresses do not exist.

Optional Feature:
- Macro: SDPRAM_SYNC_CLR_FWD_EN.
- Defined:
  - A same-cycle, same-address read/write returns the new data, merged per lane: written lanes come from wr_data, other lanes from the array.
  - Forwarding also covers a write in cycle N+1 hitting an OUTPUT_REG-stage read issued in cycle N; the registered output is updated.
  - Forwarding never applies to clear-sweep writes.
- Undefined: read-first semantics with no bypass logic.

Decomposition:
- Shared package `sdpram_pkg`:
  - FSM state enum (ST_IDLE, ST_CLEAR);
  - helper function for lane count (DATA_WIDTH/BYTE_SIZE);
  - lane-merge function (old, new, byte_en) -> word, used by both the write path and the forwarding path.
- One sub-module, `sdpram_sync_clr_core`: the inferred array with per-lane write and registered read. The top holds the FSM, counter, write mux, output stage and forwarding.

Test Plan:
- Use ADDR_WIDTH=4, OUTPUT_REG=0, CLR_ON_RST=1.
- Release `rst` -> clr_busy high exactly 16 cycles; a read of every address then returns 0 with rd_valid one cycle after rd_en.
- Write 0x3FFFF to address 5 with wr_byte_en=2'b01, then read address 5 -> rd_data=0x001FF (lower 9-bit lane only).
- Pulse clr_req after filling the array with 0x15555; issue wr_en to address 3 during the sweep -> write dropped, rd_valid stays 0; after busy falls, address 3 reads 0.
- Assert `rst` at sweep cycle 8 for 2 cycles -> clr_busy=0 during reset, then high for a fresh 16 cycles.
- Use OUTPUT_REG=1 with back-to-back reads of addresses 1,2,3 -> rd_valid high for 3 consecutive cycles, first result 2 cycles after the first rd_en, data in order.
- Same-cycle read/write to address 7 (old 0x00AAA, new 0x12345, all lanes) -> 0x00AAA with the macro off, 0x12345 with SDPRAM_SYNC_CLR_FWD_EN defined.
